// File: rtl/ula_pkg.sv
// ula_pkg: shared types and constants for the ZX Spectrum ULA blocks.
//   speed_t            CPU clock speed selector (1x/2x/4x/8x)
//   T_STATES_PER_FRAME T-states in one 48K video frame
//   TCNT_W_DEFAULT     counter width that holds one frame of T-states
package ula_pkg;

    typedef enum logic [1:0] {
        SPEED_1X = 2'd0,
        SPEED_2X = 2'd1,
        SPEED_4X = 2'd2,
        SPEED_8X = 2'd3
    } speed_t;

    localparam int unsigned T_STATES_PER_FRAME = 69888;
    localparam int unsigned TCNT_W_DEFAULT     = $clog2(T_STATES_PER_FRAME);

endpackage

// File: rtl/cpu_clkgen.sv
// cpu_clkgen: divides the ULA clock into the Z80 CPU clock at one of four
// speeds, changing speed only at falling edges of clk_cpu so that no runt
// pulses are produced. Also produces one-cycle edge strobes and a T-state
// counter that restarts on frame_sync.
//
// Optional build macro:
//   CPU_CLKGEN_CONTENTION_EN  honour stall (stretch the high phase of clk_cpu)
//
// Ports:
//   clk_ula     ULA clock
//   reset       synchronous, active-high reset
//   speed       requested speed (speed_t)
//   stall       contention request, holds clk_cpu high at the end of its high phase
//   frame_sync  one-cycle pulse restarting the T-state count
//   clk_cpu     CPU clock (registered)
//   cpu_rise    one-cycle strobe coincident with clk_cpu going high
//   cpu_fall    one-cycle strobe coincident with clk_cpu going low
//   tcount      clk_cpu rising edges since the last frame_sync
import ula_pkg::*;

module cpu_clkgen #(
    parameter int unsigned BASE_HALF = 2,
    parameter int unsigned HALF_W    = 4,
    parameter int unsigned TCNT_W    = TCNT_W_DEFAULT
) (
    input  logic              clk_ula,
    input  logic              reset,
    input  speed_t            speed,
    input  logic              stall,
    input  logic              frame_sync,
    output logic              clk_cpu,
    output logic              cpu_rise,
    output logic              cpu_fall,
    output logic [TCNT_W-1:0] tcount
);

    // Reload value for the half-period counter: max(BASE_HALF >> s, 1) - 1.
    function automatic logic [HALF_W-1:0] reload_val(speed_t s);
        int unsigned h;
        h = BASE_HALF >> int'(s);
        if (h == 0) begin
            h = 1;
        end
        return HALF_W'(h - 1);
    endfunction

    logic [HALF_W-1:0] cnt;
    logic [HALF_W-1:0] cnt_n;
    speed_t            speed_q;
    speed_t            speed_q_n;
    logic              clk_n;
    logic              rise_n;
    logic              fall_n;
    logic [TCNT_W-1:0] tcount_n;
    logic              hold;

    // Contention only ever delays the falling edge.
`ifdef CPU_CLKGEN_CONTENTION_EN
    assign hold = clk_cpu & stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign hold         = 1'b0;
`endif

    // Next-state: divider, speed latch at the falling edge, edge strobes, T-state count.
    always_comb begin
        cnt_n     = cnt;
        speed_q_n = speed_q;
        clk_n     = clk_cpu;
        rise_n    = 1'b0;
        fall_n    = 1'b0;
        tcount_n  = tcount;

        if (cnt == '0) begin
            if (!hold) begin
                clk_n  = ~clk_cpu;
                rise_n = ~clk_cpu;
                fall_n = clk_cpu;
                // New speed takes effect for the whole of the next period.
                if (clk_cpu) begin
                    speed_q_n = speed;
                end
                cnt_n = reload_val(speed_q_n);
            end
        end else begin
            cnt_n = cnt - HALF_W'(1);
        end

        // A rise coincident with frame_sync is the first edge of the new frame.
        if (frame_sync) begin
            tcount_n = TCNT_W'(rise_n);
        end else if (rise_n) begin
            tcount_n = tcount + TCNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_ula) begin
        if (reset) begin
            cnt      <= HALF_W'(BASE_HALF - 1);
            speed_q  <= SPEED_1X;
            clk_cpu  <= 1'b0;
            cpu_rise <= 1'b0;
            cpu_fall <= 1'b0;
            tcount   <= '0;
        end else begin
            cnt      <= cnt_n;
            speed_q  <= speed_q_n;
            clk_cpu  <= clk_n;
            cpu_rise <= rise_n;
            cpu_fall <= fall_n;
            tcount   <= tcount_n;
        end
    end

endmodule

// File: tb/tb_cpu_clkgen.sv
// tb_cpu_clkgen: self-checking bench for cpu_clkgen. Two instances run side by
// side: A (BASE_HALF=2, default widths) and B (BASE_HALF=8, 4-bit T-state count).
// A timeline model predicts edge times per instance.
import ula_pkg::*;

module tb_cpu_clkgen;

`ifdef CPU_CLKGEN_CONTENTION_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, stall_a, fs_a;
    speed_t      speed_a;
    logic        clk_a, rise_a, fall_a;
    logic [16:0] tc_a;

    logic        rst_b, stall_b, fs_b;
    speed_t      speed_b;
    logic        clk_b, rise_b, fall_b;
    logic [3:0]  tc_b;

    cpu_clkgen #(.BASE_HALF(2), .HALF_W(4), .TCNT_W(17)) dut_a (
        .clk_ula(clk), .reset(rst_a), .speed(speed_a), .stall(stall_a),
        .frame_sync(fs_a), .clk_cpu(clk_a), .cpu_rise(rise_a),
        .cpu_fall(fall_a), .tcount(tc_a)
    );

    cpu_clkgen #(.BASE_HALF(8), .HALF_W(4), .TCNT_W(4)) dut_b (
        .clk_ula(clk), .reset(rst_b), .speed(speed_b), .stall(stall_b),
        .frame_sync(fs_b), .clk_cpu(clk_b), .cpu_rise(rise_b),
        .cpu_fall(fall_b), .tcount(tc_b)
    );

    int checks = 0;
    int errors = 0;

    // Timeline model: absolute cycle of the next scheduled clk_cpu edge.
    int     base [2] = '{2, 8};
    int     tw   [2] = '{17, 4};
    int     cyc  [2];
    int     nxt  [2];
    int     sq   [2];
    bit     lvl  [2];
    bit     mr   [2];
    bit     mf   [2];
    longint tc   [2];

    function automatic int hv(int b, int s);
        int h;
        h = b >> s;
        return (h < 1) ? 1 : h;
    endfunction

    task automatic model_edge(input int i, input bit r, input int spd, input bit st, input bit fs);
        if (r) begin
            lvl[i] = 0; sq[i] = 0; mr[i] = 0; mf[i] = 0; tc[i] = 0;
            cyc[i] = 0; nxt[i] = hv(base[i], 0);
        end else begin
            cyc[i]++;
            mr[i] = 0; mf[i] = 0;
            if (cyc[i] == nxt[i]) begin
                if (lvl[i] && STALL_EN && st) begin
                    nxt[i] = cyc[i] + 1;
                end else begin
                    if (lvl[i]) begin
                        sq[i] = spd;
                        mf[i] = 1;
                    end else begin
                        mr[i] = 1;
                    end
                    lvl[i] = !lvl[i];
                    nxt[i] = cyc[i] + hv(base[i], sq[i]);
                end
            end
            if (fs) tc[i] = mr[i] ? 1 : 0;
            else if (mr[i]) tc[i] = (tc[i] + 1) % (longint'(1) << tw[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, rst_a, int'(speed_a), stall_a, fs_a);
        model_edge(1, rst_b, int'(speed_b), stall_b, fs_b);
        #1;
    endtask

    // Step until the requested strobe appears; n = steps taken, -1 on timeout.
    task automatic wait_edge(input int inst, input bit want_rise, output int n);
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            logic hit;
            step();
            if (inst == 0) hit = want_rise ? rise_a : fall_a;
            else           hit = want_rise ? rise_b : fall_b;
            if (hit) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1;
        repeat (3) step();
        checks++;
        if ({clk_a, rise_a, fall_a, tc_a} !== 20'd0) begin
            errors++;
            $display("FAIL reset_a got %b %b %b %0d want 0 0 0 0", clk_a, rise_a, fall_a, tc_a);
        end
        checks++;
        if ({clk_b, rise_b, fall_b, tc_b} !== 7'd0) begin
            errors++;
            $display("FAIL reset_b got %b %b %b %0d want 0 0 0 0", clk_b, rise_b, fall_b, tc_b);
        end
        rst_a = 0; rst_b = 0;
    endtask

    task automatic test_1x();
        int n;
        wait_edge(0, 1, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL first_rise got %0d want 2", n); end
        wait_edge(0, 0, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL high_1x got %0d want 2", n); end
        wait_edge(0, 1, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL low_1x got %0d want 2", n); end
        repeat (8) wait_edge(0, 1, n);
        checks++;
        if (tc_a !== 17'd10) begin errors++; $display("FAIL tcount_10 got %0d want 10", tc_a); end
    endtask

    task automatic test_2x();
        int n, nr, nf;
        rst_a = 1; speed_a = SPEED_2X;
        step();
        rst_a = 0;
        wait_edge(0, 1, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL rise_2x_first got %0d want 2", n); end
        wait_edge(0, 0, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL high_before_latch got %0d want 2", n); end
        nr = 0; nf = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            nr += int'(rise_a);
            nf += int'(fall_a);
            checks++;
            if ({clk_a, rise_a, fall_a, tc_a} !== {lvl[0], mr[0], mf[0], 17'(tc[0])}) begin
                errors++;
                $display("FAIL model_2x got %b%b%b/%0d want %b%b%b/%0d", clk_a, rise_a, fall_a, tc_a,
                         lvl[0], mr[0], mf[0], tc[0]);
            end
        end
        checks++;
        if (nr !== 5 || nf !== 5) begin
            errors++;
            $display("FAIL strobes_2x got rises %0d falls %0d want 5 5", nr, nf);
        end
    endtask

    task automatic test_speed_switch();
        int n;
        speed_b = SPEED_1X;
        wait_edge(1, 1, n);
        repeat (3) step();
        speed_b = SPEED_4X;
        wait_edge(1, 0, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL old_high_rest got %0d want 5", n); end
        wait_edge(1, 1, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL new_low got %0d want 2", n); end
        wait_edge(1, 0, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL new_high got %0d want 2", n); end
    endtask

    task automatic test_stall();
        int n, h;
        speed_a = SPEED_1X;
        wait_edge(0, 0, n);
        wait_edge(0, 1, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL stall_setup_low got %0d want 2", n); end
        h = 0;
        for (int k = 0; k < 12; k++) begin
            stall_a = (k >= 1 && k <= 5);
            step();
            h++;
            if (fall_a) break;
        end
        stall_a = 0;
        checks++;
        if (h !== (STALL_EN ? 7 : 2)) begin
            errors++;
            $display("FAIL stall_high got %0d want %0d", h, STALL_EN ? 7 : 2);
        end
        stall_a = 1;
        wait_edge(0, 1, n);
        stall_a = 0;
        checks++;
        if (n !== 2) begin errors++; $display("FAIL stall_low_ignored got %0d want 2", n); end
    endtask

    task automatic test_frame_sync();
        for (int k = 0; k < 20; k++) begin
            if (lvl[0] == 0 && nxt[0] == cyc[0] + 1) break;
            step();
        end
        fs_a = 1;
        step();
        fs_a = 0;
        checks++;
        if (rise_a !== 1'b1 || tc_a !== 17'd1) begin
            errors++;
            $display("FAIL fs_with_rise got rise %b tcount %0d want 1 1", rise_a, tc_a);
        end
        fs_a = 1;
        step();
        fs_a = 0;
        checks++;
        if (rise_a !== 1'b0 || tc_a !== 17'd0) begin
            errors++;
            $display("FAIL fs_alone got rise %b tcount %0d want 0 0", rise_a, tc_a);
        end
    endtask

    task automatic test_tcount_wrap();
        int n;
        speed_b = SPEED_8X;
        wait_edge(1, 0, n);
        wait_edge(1, 1, n);
        fs_b = 1;
        step();
        fs_b = 0;
        checks++;
        if (tc_b !== 4'd0) begin errors++; $display("FAIL wrap_start got %0d want 0", tc_b); end
        repeat (15) wait_edge(1, 1, n);
        checks++;
        if (tc_b !== 4'd15) begin errors++; $display("FAIL wrap_max got %0d want 15", tc_b); end
        wait_edge(1, 1, n);
        checks++;
        if (tc_b !== 4'd0 || n !== 2) begin
            errors++;
            $display("FAIL wrap_zero got %0d (gap %0d) want 0 (gap 2)", tc_b, n);
        end
    endtask

    task automatic test_reset_mid_high();
        int n;
        speed_a = SPEED_2X;
        wait_edge(0, 1, n);
        rst_a = 1;
        step();
        checks++;
        if ({clk_a, fall_a, tc_a} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid_high got clk %b fall %b tcount %0d want 0 0 0", clk_a, fall_a, tc_a);
        end
        rst_a = 0;
        wait_edge(0, 1, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL post_reset_rise got %0d want 2", n); end
        wait_edge(0, 0, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL post_reset_1x_high got %0d want 2", n); end
        wait_edge(0, 1, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL post_reset_2x_low got %0d want 1", n); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) speed_a = speed_t'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) speed_b = speed_t'($urandom_range(0, 3));
            stall_a = ($urandom_range(0, 2) == 0);
            stall_b = ($urandom_range(0, 2) == 0);
            fs_a    = ($urandom_range(0, 40) == 0);
            fs_b    = ($urandom_range(0, 40) == 0);
            rst_a   = ($urandom_range(0, 300) == 0);
            rst_b   = ($urandom_range(0, 300) == 0);
            step();
            checks++;
            if ({clk_a, rise_a, fall_a, tc_a} !== {lvl[0], mr[0], mf[0], 17'(tc[0])}) begin
                errors++;
                $display("FAIL rand_a cyc %0d got %b%b%b/%0d want %b%b%b/%0d", k, clk_a, rise_a, fall_a,
                         tc_a, lvl[0], mr[0], mf[0], tc[0]);
            end
            checks++;
            if ({clk_b, rise_b, fall_b, tc_b} !== {lvl[1], mr[1], mf[1], 4'(tc[1])}) begin
                errors++;
                $display("FAIL rand_b cyc %0d got %b%b%b/%0d want %b%b%b/%0d", k, clk_b, rise_b, fall_b,
                         tc_b, lvl[1], mr[1], mf[1], tc[1]);
            end
        end
        rst_a = 0; rst_b = 0; stall_a = 0; stall_b = 0; fs_a = 0; fs_b = 0;
    endtask

    initial begin
        rst_a = 1; stall_a = 0; fs_a = 0; speed_a = SPEED_1X;
        rst_b = 1; stall_b = 0; fs_b = 0; speed_b = SPEED_1X;
        test_reset();
        test_1x();
        test_2x();
        test_speed_switch();
        test_stall();
        test_frame_sync();
        test_tcount_wrap();
        test_reset_mid_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_clkgen.md
# cpu_clkgen

Parametrised Z80 CPU clock generator for the ZX Spectrum ULA, successor to the fixed divide-by-4/turbo divider. It divides the ULA clock into the CPU clock at one of four selectable speeds and switches speed only at full-period boundaries. It optionally stretches the high phase for video RAM contention. It also provides single-cycle edge strobes and a per-frame T-state counter for the video and interrupt logic.

## Interface
Parameters:
- BASE_HALF, 2: half-period of clk_cpu in clk_ula cycles at 1x speed (14 MHz / 4 = 3.5 MHz); must be ≥1.
- HALF_W, 4: width of the half-period counter; must hold BASE_HALF-1.
- TCNT_W, 17: width of the T-state counter (69888 T-states per 48K frame).

Ports (one clock; reset is synchronous and active-high):
- clk_ula  input  1  ULA clock, 14 MHz.
- reset  input  1  synchronous, active-high reset.
- speed  input  2  requested speed; a ula_pkg::speed_t value (0=1x, 1=2x, 2=4x, 3=8x).
- stall  input  1  contention request; holds clk_cpu high (CONTENTION_EN only).
- frame_sync  input  1  one-cycle pulse that restarts the T-state count.
- clk_cpu  output  1  CPU clock, registered.
- cpu_rise  output  1  high for one clk_ula cycle when clk_cpu goes 0→1.
- cpu_fall  output  1  high for one clk_ula cycle when clk_cpu goes 1→0.
- tcount  output  TCNT_W  number of clk_cpu rising edges since the last frame_sync.

## Operation
- Active half-period: half = max(BASE_HALF >> speed_q, 1), where speed_q is the latched speed.
- Counter cnt counts down. When cnt==0, clk_cpu toggles and cnt reloads half-1 (half computed from the new speed_q if it was just latched). Otherwise cnt decrements.
- Speed latch: speed_q ← speed only on a toggle where clk_cpu is currently 1 (the falling edge, a full-period boundary). The low and high phases of any one period therefore always use the same half, so no runt pulses occur.
- speed=1 with BASE_HALF=2 reproduces the legacy turbo mode (7 MHz).
- Stall (CONTENTION_EN): if clk_cpu==1, cnt==0 and stall==1, clk_cpu does not toggle and cnt stays 0. The falling edge occurs on the first cycle with stall==0. Stall is ignored during the low phase and while cnt≠0.
- tcount: increments, wrapping modulo 2^TCNT_W, on every cycle where cpu_rise is asserted.
  - frame_sync alone sets tcount to 0.
  - frame_sync coincident with cpu_rise sets tcount to 1, so the edge counts in the new frame.
- Reset values: clk_cpu=0, cnt=BASE_HALF-1, speed_q=0 (1x), cpu_rise=0, cpu_fall=0, tcount=0. Reset overrides stall and frame_sync.
- Reset asserted mid-period aborts the period with no extra edge. clk_cpu drops to 0 on the reset cycle, and cpu_fall stays 0.

## Timing
- All outputs are registered. cpu_rise and cpu_fall assert in the same cycle that clk_cpu takes its new value.
- After reset deasserts (1x, BASE_HALF=2): cnt goes 1→0, then clk_cpu rises on the 2nd clk_ula edge. Period is 4 cycles with 50% duty.
- Speed change latency: applied at the next falling edge of clk_cpu, at most 2·half_old cycles after the request. The new period begins immediately after that edge.
- Stall adds exactly N cycles to the high phase for N consecutive stalled cycles at the cnt==0 point.
- At 8x with BASE_HALF=2, half saturates to 1, giving 7 MHz (same as 2x).

## Configuration
- CPU_CLKGEN_CONTENTION_EN defined: the stall input is honoured as described above.
- CPU_CLKGEN_CONTENTION_EN undefined: the stall port remains on the interface but is ignored, and clk_cpu is never stretched.

## Structure
- ula_pkg holds:
  - typedef enum logic [1:0] speed_t {SPEED_1X, SPEED_2X, SPEED_4X, SPEED_8X};
  - T_STATES_PER_FRAME = 69888, which sets the TCNT_W default.
- A single flat module. The half-period computation is a small function; no sub-module is warranted.

## Test plan
- Reset, speed=0, BASE_HALF=2 → first cpu_rise at the 2nd cycle after reset release; clk_cpu period 4, duty 2/2; tcount = 10 after 10 rises.
- speed=1 held from reset → rising edge, then 2-cycle period; cpu_rise and cpu_fall each pulse once per period.
- Switch speed 0→2 with BASE_HALF=8 while mid-high-phase → current period completes at 16 cycles, then the next periods are 4 cycles; no pulse is shorter than 2 cycles.
- CONTENTION_EN: stall held high for 5 cycles starting at cnt==0 in the high phase → high phase lasts 7 cycles, cpu_fall occurs on the first cycle after stall drops. Stall during the low phase has no effect. With the macro undefined, the high phase stays 2 cycles.
- frame_sync coincident with cpu_rise → tcount=1; frame_sync alone → tcount=0; tcount at 2^TCNT_W-1 plus one rise → 0.
- Reset asserted while clk_cpu=1 → clk_cpu=0, cpu_fall=0, tcount=0 on that cycle; speed returns to 1x.
